conv_frame_sequencer: RTL and testbench

//  Sequences the 6x6 binary convolution datapath from the board buttons: synchronises
//  and edge-detects the load/start buttons, captures six 6-bit rows into a frame buffer,

---
 rtl/conv_frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Sequences the 6x6 binary convolution datapath from the board buttons.
//   The load/start buttons are synchronised and edge-detected. Load presses
//   capture 6-bit rows into a frame buffer. A start press runs a six-cycle,
//   row-serial accumulate of popcount(frame row AND kernel row). The 6-bit
//   match count is then presented together with a valid flag.
// Ports
//   clk        : single clock, all state updates on posedge
//   rst_n      : asynchronous active-low reset
//   ui_in      : [5:0] row data, [6] load button, [7] start button
//   sum_out    : accumulated match count (0..36), updated on COMPUTE->DONE
//   sum_valid  : high while in DONE
//   busy       : high while in COMPUTE
//   row_idx    : number of rows written in the current frame (0..6)
//   frame_out  : frame buffer, row r at [r*COLS +: COLS]
//   err        : sticky flag, a button edge was dropped; cleared by reset only
module conv_frame_sequencer #(
   parameter int                     ROWS        = 6,
   parameter int                     COLS        = 6,
   parameter int                     SYNC_STAGES = 2,
   parameter logic [ROWS*COLS-1:0]   KERNEL      = 36'hF_FFFF_FFFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             ui_in,
   output logic [5:0]             sum_out,
   output logic                   sum_valid,
   output logic                   busy,
   output logic [2:0]             row_idx,
   output logic [ROWS*COLS-1:0]   frame_out,
   output logic                   err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FULL,
      S_COMPUTE,
      S_DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] load_sync_reg, start_sync_reg;
   logic                   load_d_reg, start_d_reg;
   logic [2:0]             row_idx_reg, row_idx_next;
   logic [2:0]             step_reg, step_next;
   logic [5:0]             acc_reg, acc_next;
   logic [5:0]             sum_reg, sum_next;
   logic                   err_reg, err_next;
   logic [ROWS*COLS-1:0]   frame_reg, frame_next;

   logic                   load_rise, start_rise;
   logic [COLS-1:0]        row_data;
   logic [5:0]             row_pop [ROWS];
   logic [5:0]             cur_pop;
   logic                   clear_frame, write_row;
   logic [2:0]             wr_idx;

   // Rising edges are taken at the synchroniser output, one cycle per press.
   assign load_rise  = load_sync_reg[SYNC_STAGES-1]  & ~load_d_reg;
   assign start_rise = start_sync_reg[SYNC_STAGES-1] & ~start_d_reg;
   // Row data is not synchronised: the user holds it stable while pressing load.
   assign row_data   = ui_in[COLS-1:0];

   // Per-row match counts; the compute step selects one of them each cycle.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_pop
      assign row_pop[gi] = 6'($countones(frame_reg[gi*COLS +: COLS] & KERNEL[gi*COLS +: COLS]));
   end

   always_comb begin
      cur_pop = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (step_reg == 3'(r)) cur_pop = row_pop[r];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         load_sync_reg  <= '0;
         start_sync_reg <= '0;
         load_d_reg     <= 1'b0;
         start_d_reg    <= 1'b0;
         row_idx_reg    <= '0;
         step_reg       <= '0;
         acc_reg        <= '0;
         sum_reg        <= '0;
         err_reg        <= 1'b0;
         frame_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         load_sync_reg  <= {load_sync_reg[SYNC_STAGES-2:0], ui_in[6]};
         start_sync_reg <= {start_sync_reg[SYNC_STAGES-2:0], ui_in[7]};
         load_d_reg     <= load_sync_reg[SYNC_STAGES-1];
         start_d_reg    <= start_sync_reg[SYNC_STAGES-1];
         row_idx_reg    <= row_idx_next;
         step_reg       <= step_next;
         acc_reg        <= acc_next;
         sum_reg        <= sum_next;
         err_reg        <= err_next;
         frame_reg      <= frame_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      row_idx_next = row_idx_reg;
      step_next    = step_reg;
      acc_next     = acc_reg;
      sum_next     = sum_reg;
      err_next     = err_reg;
      clear_frame  = 1'b0;
      write_row    = 1'b0;
      wr_idx       = row_idx_reg;

      case (state_reg)
         S_IDLE: begin
            // Start without a frame is silently ignored; load wins a tie here.
            if (load_rise) begin
               clear_frame  = 1'b1;
               write_row    = 1'b1;
               wr_idx       = '0;
               row_idx_next = 3'd1;
               state_next   = S_LOAD;
            end
         end
         S_LOAD, S_FULL, S_DONE: begin
            if (start_rise) begin
               // Start wins a tie; the simultaneous load is dropped.
               if (load_rise) err_next = 1'b1;
               acc_next   = '0;
               step_next  = '0;
               state_next = S_COMPUTE;
            end else if (load_rise) begin
               if (state_reg == S_FULL) begin
                  err_next = 1'b1;
               end else if (state_reg == S_DONE) begin
                  clear_frame  = 1'b1;
                  write_row    = 1'b1;
                  wr_idx       = '0;
                  row_idx_next = 3'd1;
                  state_next   = S_LOAD;
               end else begin
                  write_row    = 1'b1;
                  row_idx_next = row_idx_reg + 3'd1;
                  if (row_idx_reg == 3'(ROWS-1)) state_next = S_FULL;
               end
            end
         end
         S_COMPUTE: begin
            if (load_rise || start_rise) err_next = 1'b1;
            acc_next  = acc_reg + cur_pop;
            step_next = step_reg + 3'd1;
            if (step_reg == 3'(ROWS-1)) begin
               sum_next   = acc_reg + cur_pop;
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      frame_next = clear_frame ? '0 : frame_reg;
      if (write_row) begin
         for (int r = 0; r < ROWS; r++) begin
            if (wr_idx == 3'(r)) frame_next[r*COLS +: COLS] = row_data;
         end
      end
   end

   assign sum_out   = sum_reg;
   assign sum_valid = (state_reg == S_DONE);
   assign busy      = (state_reg == S_COMPUTE);
   assign row_idx   = row_idx_reg;
   assign frame_out = frame_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;
   localparam logic [35:0] KERNEL = 36'hF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ui_in = '0;
   logic [5:0]  sum_out;
   logic        sum_valid, busy, err;
   logic [2:0]  row_idx;
   logic [35:0] frame_out;

   int n_pass = 0;
   int n_total = 0;

   // Behavioural model: frame as an array of rows, phase 0=idle 1=loading 2=result shown
   int m_frame [6];
   int m_rows, m_phase, m_sum;
   bit m_err;

   conv_frame_sequencer #(.ROWS(6), .COLS(6), .SYNC_STAGES(2), .KERNEL(KERNEL)) dut (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .sum_out(sum_out), .sum_valid(sum_valid),
      .busy(busy), .row_idx(row_idx), .frame_out(frame_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [35:0] m_pack();
      logic [35:0] f = '0;
      for (int r = 0; r < 6; r++) f = f | (36'(m_frame[r] & 63) << (6 * r));
      return f;
   endfunction

   function automatic int m_score();
      int s = 0;
      logic [5:0] krow, frow;
      logic [35:0] k = KERNEL;
      for (int r = 0; r < 6; r++) begin
         krow = k[r*6 +: 6];
         frow = 6'(m_frame[r]);
         s += $countones(frow & krow);
      end
      return s;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 6; r++) m_frame[r] = 0;
      m_rows = 0; m_phase = 0; m_sum = 0; m_err = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".busy"}, 64'(busy), 64'(0));
      chk({tag, ".valid"}, 64'(sum_valid), 64'(m_phase == 2));
      chk({tag, ".sum"}, 64'(sum_out), 64'(m_sum));
      chk({tag, ".row_idx"}, 64'(row_idx), 64'(m_rows));
      chk({tag, ".frame"}, 64'(frame_out), 64'(m_pack()));
      chk({tag, ".err"}, 64'(err), 64'(m_err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
   endtask

   // One button press: drive at a negedge, action lands on the 3rd posedge.
   task automatic press(input string tag, input bit ld, input bit st, input logic [5:0] d, input bit retrig);
      bit go;
      int old_sum;
      logic [35:0] old_frame;
      logic [2:0]  old_rows;
      @(negedge clk);
      ui_in = {st, ld, d};
      old_frame = m_pack();
      old_rows  = 3'(m_rows);
      old_sum   = m_sum;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, ".pre_rows"}, 64'(row_idx), 64'(old_rows));
      chk({tag, ".pre_busy"}, 64'(busy), 64'(0));
      go = 0;
      if (m_phase == 0) begin
         if (ld) begin
            for (int r = 0; r < 6; r++) m_frame[r] = 0;
            m_frame[0] = int'(d); m_rows = 1; m_phase = 1;
         end
      end else if (st) begin
         if (ld) m_err = 1;
         go = 1;
      end else if (ld) begin
         if (m_phase == 2) begin
            for (int r = 0; r < 6; r++) m_frame[r] = 0;
            m_frame[0] = int'(d); m_rows = 1; m_phase = 1;
         end else if (m_rows == 6) m_err = 1;
         else begin
            m_frame[m_rows] = int'(d); m_rows++;
         end
      end
      @(posedge clk);
      if (go) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) ui_in[7:6] = 2'b00;
            if (k == 2 && retrig) ui_in[7] = 1'b1;
            chk({tag, ".busy"}, 64'(busy), 64'(1));
            chk({tag, ".hold_sum"}, 64'(sum_out), 64'(old_sum));
            chk({tag, ".cmp_frame"}, 64'(frame_out), 64'(old_frame));
            @(posedge clk);
         end
         m_sum = m_score();
         m_phase = 2;
         if (retrig) m_err = 1;
         @(negedge clk);
         chk({tag, ".done_valid"}, 64'(sum_valid), 64'(1));
         chk({tag, ".done_sum"}, 64'(sum_out), 64'(m_sum));
      end else begin
         @(negedge clk);
         chk({tag, ".act_rows"}, 64'(row_idx), 64'(m_rows));
      end
      ui_in[7:6] = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all(tag);
      $display("press %s ld=%0d st=%0d d=%02h -> sum=%0d valid=%0d rows=%0d err=%0d",
               tag, ld, st, d, sum_out, sum_valid, row_idx, err);
   endtask

   initial begin
      m_reset();
      ui_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("por");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: full frame of ones
      do_reset();
      for (int i = 0; i < 6; i++) press("t1_load", 1, 0, 6'h3F, 0);
      press("t1_start", 0, 1, 6'h00, 0);
      chk("t1_sum36", 64'(sum_out), 64'(36));
      // restart on the same frame with a start edge arriving mid-compute
      press("t1_retrig", 0, 1, 6'h00, 1);

      // 2: staircase rows
      do_reset();
      press("t2_load", 1, 0, 6'h01, 0);
      press("t2_load", 1, 0, 6'h03, 0);
      press("t2_load", 1, 0, 6'h07, 0);
      press("t2_load", 1, 0, 6'h0F, 0);
      press("t2_load", 1, 0, 6'h1F, 0);
      press("t2_load", 1, 0, 6'h3F, 0);
      press("t2_start", 0, 1, 6'h00, 0);
      chk("t2_sum21", 64'(sum_out), 64'(21));

      // 3: partial frame loaded from DONE
      press("t3_load", 1, 0, 6'h3F, 0);
      press("t3_load", 1, 0, 6'h3F, 0);
      press("t3_start", 0, 1, 6'h00, 0);
      chk("t3_sum12", 64'(sum_out), 64'(12));

      // 4: seventh load in FULL
      do_reset();
      for (int i = 0; i < 6; i++) press("t4_load", 1, 0, 6'(i + 9), 0);
      press("t4_load7", 1, 0, 6'h2A, 0);

      // 5: simultaneous load and start in LOAD
      do_reset();
      press("t5_load", 1, 0, 6'h3F, 0);
      press("t5_load", 1, 0, 6'h15, 0);
      press("t5_both", 1, 1, 6'h3F, 0);

      // 6: reset during the third compute cycle
      do_reset();
      press("t6_load", 1, 0, 6'h3F, 0);
      @(negedge clk);
      ui_in[7] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ui_in[7] = 1'b0;
      chk("t6_busy", 64'(busy), 64'(1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      press("t6_idle_start", 0, 1, 6'h00, 0);

      // randomized presses
      do_reset();
      for (int i = 0; i < 40; i++) begin
         bit ld, st, rt;
         ld = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 3) == 0);
         rt = ($urandom_range(0, 3) == 0);
         if (!ld && !st) ld = 1;
         if (i == 20) do_reset();
         press("rnd", ld, st, 6'($urandom), rt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
